// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter.
//   arb_state_e : arbiter FSM state encoding (idle / memory access / response pulse)
//   arb_op_e    : operation latched for the granted port
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_e;

endpackage

// File: rtl/mem_arbiter_arb_select.sv
// Combinational winner selection for mem_arbiter.
// Default: fixed priority, highest requesting index wins.
// With MEM_ARB_RR_EN defined: round-robin, scanning upward from ptr+1 with wrap.
// Ports:
//   req     in  per-port request vector
//   ptr     in  last granted index (only present with MEM_ARB_RR_EN)
//   gnt_oh  out one-hot winner (all zero when nothing requests)
//   gnt_idx out binary winner index (zero when nothing requests)
module mem_arbiter_arb_select #(
  parameter int unsigned NUM_PORTS = 3,
  localparam int unsigned IdxW     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
`ifdef MEM_ARB_RR_EN
  input  logic [IdxW-1:0]      ptr,
`endif
  output logic [NUM_PORTS-1:0] gnt_oh,
  output logic [IdxW-1:0]      gnt_idx
);

`ifdef MEM_ARB_RR_EN
  // Walk offsets from farthest (ptr itself) to nearest (ptr+1) so the nearest
  // requester after the pointer is the last assignment and therefore wins.
  always_comb begin
    logic [IdxW-1:0] cand;
    gnt_oh  = '0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = int'(NUM_PORTS); k >= 1; k--) begin
      cand = IdxW'((int'(ptr) + k) % int'(NUM_PORTS));
      if (req[cand]) begin
        gnt_oh       = '0;
        gnt_oh[cand] = 1'b1;
        gnt_idx      = cand;
      end
    end
  end
`else
  // Ascending scan: the highest requesting index is assigned last and wins.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (req[i]) begin
        gnt_oh    = '0;
        gnt_oh[i] = 1'b1;
        gnt_idx   = IdxW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Registered arbiter multiplexing NUM_PORTS pipeline-stage requesters onto one
// memory port with a ready handshake. Each transaction walks IDLE -> BUSY -> RESP;
// the winner's op/address/data are latched on leaving IDLE, memory strobes are
// registered, and done pulses for one cycle in RESP.
// Optional feature macro: MEM_ARB_RR_EN (round-robin grant, no blocked cascade).
// Ports:
//   clock, reset          sole clock (rising edge), synchronous active-high reset
//   req_read/req_write    per-port request; both high means write
//   req_addr/req_wdata    flattened per-port address / write data
//   blocked               per-port stall flag (combinational)
//   done                  one-cycle completion pulse per port
//   rdata                 read data captured from memory, valid with done
//   mem_read/mem_write    registered memory strobes
//   mem_addr/mem_wdata    registered memory address / write data
//   mem_rdata/mem_ready   memory response
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req_read,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        blocked,
  output logic [NUM_PORTS-1:0]        done,
  output logic [DATA_W-1:0]           rdata,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_ready
);

  localparam int unsigned IdxW = $clog2(NUM_PORTS);

  arb_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0] requesting, pending;
  logic [NUM_PORTS-1:0] sel_oh, grant_oh_q;
  logic [IdxW-1:0]      sel_idx;
  arb_op_e              sel_op;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic                 any_req, load, capture;

`ifdef MEM_ARB_RR_EN
  logic [IdxW-1:0]      ptr_q;
`endif

  assign requesting = req_read | req_write;
  assign any_req    = |requesting;

  mem_arbiter_arb_select #(
    .NUM_PORTS(NUM_PORTS)
  ) u_arb_select (
    .req    (requesting),
`ifdef MEM_ARB_RR_EN
    .ptr    (ptr_q),
`endif
    .gnt_oh (sel_oh),
    .gnt_idx(sel_idx)
  );

  // Payload of the winning port; a port asserting both read and write writes.
  always_comb begin
    sel_op    = OP_READ;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (sel_idx == IdxW'(i)) begin
        sel_op    = req_write[i] ? OP_WRITE : OP_READ;
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign load    = (state_q == ARB_IDLE) && any_req;
  assign capture = (state_q == ARB_BUSY) && mem_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (any_req) state_d = ARB_BUSY;
      ARB_BUSY: if (mem_ready) state_d = ARB_RESP;
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      grant_oh_q <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata      <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        grant_oh_q <= sel_oh;
        mem_read   <= (sel_op == OP_READ);
        mem_write  <= (sel_op == OP_WRITE);
        mem_addr   <= sel_addr;
        mem_wdata  <= sel_wdata;
      end
      // Strobes drop as the access completes so RESP presents an idle bus.
      if (capture) begin
        rdata     <= mem_rdata;
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= IdxW'(NUM_PORTS - 1);
    end else if (load) begin
      ptr_q <= sel_idx;
    end
  end
`endif

  assign done    = (state_q == ARB_RESP) ? grant_oh_q : '0;
  assign pending = requesting & ~done;

`ifdef MEM_ARB_RR_EN
  assign blocked = pending;
`else
  // A stalled later stage freezes every earlier stage behind it.
  always_comb begin
    logic acc;
    acc     = 1'b0;
    blocked = '0;
    for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
      acc        = acc | pending[i];
      blocked[i] = acc;
    end
  end
`endif

endmodule
